// File: rtl/rmii_frame_transmitter.sv
// rtl/rmii_frame_transmitter.sv - RMII transmit path: preamble/SFD, pad, CRC-32 FCS, inter-frame gap
// Frames arrive one byte at a time through a single holding register and leave as LSB-first dibits.
module rmii_frame_transmitter #(
    parameter int MIN_FRAME_BYTES      = 60,
    parameter int PREAMBLE_BYTES       = 7,
    parameter int INTERFRAME_GAP_BYTES = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] transmit_data,
    input  logic       transmit_data_enable,
    output logic       transmit_data_ready,
    output logic [1:0] rmii_transmit_data,
    output logic       rmii_transmit_data_valid,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, GAP, DRAIN} state_t;

    localparam logic [7:0]  PREAMBLE_LAST = 8'(PREAMBLE_BYTES * 4 - 1);
    // The first GAP cycle still shows the final FCS dibit on the wire, hence no -1.
    localparam logic [7:0]  GAP_LAST      = 8'(INTERFRAME_GAP_BYTES * 4);
    localparam logic [10:0] MIN_COUNT     = 11'(MIN_FRAME_BYTES);

    state_t      state, state_next;
    logic [8:0]  hold_data, cur_byte;
    logic        hold_full, hold_full_next, hold_load;
    logic [31:0] crc, fcs_word;
    logic [10:0] byte_cnt, count_next;
    logic [7:0]  cnt;
    logic        handshake, byte_end, fetch, abort, fcs_last;
    logic        valid_c;
    logic [1:0]  dibit_c;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign handshake  = transmit_data_enable && transmit_data_ready;
    assign byte_end   = (cnt[1:0] == 2'd3);
    assign count_next = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign fcs_word   = ~crc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE:     if (hold_full) state_next = PREAMBLE;
            PREAMBLE: if (cnt == PREAMBLE_LAST) state_next = SFD;
            SFD: if (cnt == 8'd3) begin
                state_next = PAYLOAD;
                fetch      = 1'b1;
            end
            PAYLOAD: if (byte_end) begin
                if (cur_byte[8])
                    state_next = (count_next < MIN_COUNT) ? PAD : FCS;
                else if (hold_full)
                    fetch = 1'b1;
                else begin
                    abort      = 1'b1;
                    state_next = (handshake && transmit_data[8]) ? GAP : DRAIN;
                end
            end
            PAD:   if (byte_end && count_next == MIN_COUNT) state_next = FCS;
            FCS:   if (cnt == 8'd15) state_next = GAP;
            GAP:   if (cnt == GAP_LAST) state_next = IDLE;
            DRAIN: if (handshake && transmit_data[8]) state_next = GAP;
            default: state_next = IDLE;
        endcase
        // Bytes arriving while a frame is being abandoned belong to that frame and are dropped.
        hold_load      = handshake && (state != DRAIN) && !abort;
        hold_full_next = fetch ? 1'b0 : (hold_load ? 1'b1 : hold_full);
    end

    always_comb begin
        valid_c = 1'b0;
        dibit_c = 2'b00;
        case (state)
            PREAMBLE: begin valid_c = 1'b1; dibit_c = 2'b01; end
            SFD:      begin valid_c = 1'b1; dibit_c = (cnt == 8'd3) ? 2'b11 : 2'b01; end
            PAYLOAD:  begin valid_c = 1'b1; dibit_c = cur_byte[{cnt[1:0], 1'b0} +: 2]; end
            PAD:      begin valid_c = 1'b1; dibit_c = 2'b00; end
            FCS:      begin valid_c = 1'b1; dibit_c = fcs_word[{cnt[3:0], 1'b0} +: 2]; end
            default:  begin valid_c = 1'b0; dibit_c = 2'b00; end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt                      <= '0;
            hold_full                <= 1'b0;
            hold_data                <= '0;
            cur_byte                 <= '0;
            crc                      <= '1;
            byte_cnt                 <= '0;
            transmit_data_ready      <= 1'b0;
            rmii_transmit_data       <= 2'b00;
            rmii_transmit_data_valid <= 1'b0;
            fcs_last                 <= 1'b0;
            frame_done               <= 1'b0;
            underrun                 <= 1'b0;
        end else begin
            cnt                 <= (state_next != state) ? 8'd0 : cnt + 8'd1;
            hold_full           <= hold_full_next;
            transmit_data_ready <= (state_next == DRAIN) || !hold_full_next;
            if (hold_load) hold_data <= transmit_data;
            if (fetch)     cur_byte  <= hold_data;
            if (state == SFD && cnt == 8'd3) begin
                crc      <= '1;
                byte_cnt <= '0;
            end else if ((state == PAYLOAD || state == PAD) && byte_end) begin
                crc      <= crc_byte(crc, (state == PAD) ? 8'h00 : cur_byte[7:0]);
                byte_cnt <= count_next;
            end
            rmii_transmit_data       <= dibit_c;
            rmii_transmit_data_valid <= valid_c;
            fcs_last                 <= (state == FCS) && (cnt == 8'd15);
            frame_done               <= fcs_last;
            underrun                 <= abort;
        end
    end

endmodule

// File: doc/rmii_frame_transmitter.md
# rmii_frame_transmitter

Transmit half of an RMII switch port. Accepts frame bytes from the core data orchestrator over a valid/ready byte stream and serializes them onto the RMII transmit pins, two bits per clock. It adds preamble/SFD, pads short frames, appends the Ethernet FCS (CRC-32) and enforces the inter-frame gap. The matching receiver delivers the same 9-bit byte format in the opposite direction.

## Interface
- MIN_FRAME_BYTES, 60, minimum payload+pad bytes before FCS
- PREAMBLE_BYTES, 7, count of 0x55 bytes ahead of the SFD
- INTERFRAME_GAP_BYTES, 12, idle byte times after each frame
- clock  input  1  50 MHz RMII reference clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high; clears all state
- transmit_data  input  9  [7:0] payload byte, [8] last-byte-of-frame flag
- transmit_data_enable  input  1  transmit_data valid
- transmit_data_ready  output  1  holding register empty; byte accepted when enable && ready
- rmii_transmit_data  output  2  TXD[1:0], registered
- rmii_transmit_data_valid  output  1  TX_EN, registered
- frame_done  output  1  one-cycle pulse on the cycle after the last FCS dibit
- underrun  output  1  one-cycle pulse when a frame is aborted for missing data

## Operation
- One-byte holding register (9 bits plus full flag). Set on handshake; cleared when the FSM fetches it. transmit_data_ready = !full, registered.
- FSM states: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, GAP, DRAIN.
- IDLE: TX_EN low, TXD 00. If holding is full -> PREAMBLE. The held byte stays held; it is not consumed yet.
- PREAMBLE: sends PREAMBLE_BYTES*4 dibits of 01 -> SFD.
- SFD: sends dibits 01,01,01,11 (0xD5, LSB first). On the last dibit it fetches the holding byte, inits the CRC to 0xFFFFFFFF and clears the byte counter -> PAYLOAD.
- PAYLOAD: each byte is sent as 4 dibits, LSB first ([1:0],[3:2],[5:4],[7:6]).
  - Every byte updates the CRC (reflected poly 0xEDB88320) and the byte counter (11 bits, saturating at 2047).
  - On dibit 3, if the current byte has last=1: -> PAD when count < MIN_FRAME_BYTES, else -> FCS.
  - On dibit 3, if last=0: fetch the next byte if holding is full. If holding is empty -> underrun.
- PAD: sends 0x00 bytes, included in the CRC, until count == MIN_FRAME_BYTES -> FCS.
- FCS: sends ~crc as 16 dibits, LSB first (bits [1:0] first) -> GAP. frame_done pulses.
- GAP: TX_EN low for INTERFRAME_GAP_BYTES*4 cycles -> IDLE.
- Underrun:
  - TX_EN drops on the next cycle; no FCS is sent, so the frame is corrupt on the wire.
  - underrun pulses.
  - -> DRAIN if the aborted frame's last byte has not yet been accepted, else -> GAP.
- DRAIN: ready forced high; accepted bytes are discarded until a byte with last=1 is accepted -> GAP.
- Frames longer than 1514 bytes are transmitted unchanged. Length policing is the orchestrator's job.

## Timing
- Reset values: transmit_data_ready=0, rmii_transmit_data=00, rmii_transmit_data_valid=0, frame_done=0, underrun=0, FSM=IDLE, holding empty.
- ready rises on the first clock after reset deasserts.
- Latency from first-byte handshake to the first TX_EN-high cycle: exactly 3 clocks (hold load, IDLE decision, output register).
- Frame on the wire lasts (PREAMBLE_BYTES+1+max(N,MIN_FRAME_BYTES)+4)*4 cycles for an N-byte frame: 288 cycles when N ≤ 60.
- After the fetch on dibit 3, ready is high again one cycle later. The producer then has 3 cycles to present the next byte before the next fetch; missing that window is an underrun.
- Back-to-back frames: the next TX_EN rise is exactly INTERFRAME_GAP_BYTES*4 + 2 cycles after the previous TX_EN fall (GAP, IDLE, output register).
- Reset mid-frame: all outputs go to their reset values immediately. Any partial frame is abandoned with no FCS.
- Simultaneous handshake and fetch in the same cycle cannot occur, because ready is low whenever holding is full.

## Test plan
- Single 60-byte frame of 0x00..0x3B:
  - 28 dibits of 01, then 01,01,01,11, then payload LSB-first, then FCS.
  - A CRC over payload+FCS gives residue 0xDEBB20E3.
  - TX_EN high for exactly 288 cycles; frame_done pulses once.
- 1-byte frame 0xAB (last=1): 59 zero pad bytes, TX_EN high 288 cycles, residue 0xDEBB20E3.
- Two back-to-back 64-byte frames offered with no stall: second TX_EN rise is 50 cycles after the first fall; no underrun.
- Producer withholds byte 10 of a 64-byte frame:
  - TX_EN falls after byte 9 with no FCS, and underrun pulses once.
  - Remaining 54 bytes are accepted with ready held high and discarded.
  - GAP of 48 cycles, then the next frame transmits cleanly.
- Assert reset at byte 30 of a frame: TX_EN/TXD go to 0 in the same cycle, ready=0 while in reset, and the next frame after release transmits correctly.
- 1514-byte frame: no padding, TX_EN high (8+1514+4)*4 = 6104 cycles, residue 0xDEBB20E3.
